// File: rtl/adc_pkt_stream.sv
// adc_pkt_stream: drains NUM_CH sample channels round-robin into framed packets
// (header, payload, optional CRC-16 trailer when PKT_CRC_EN is defined, idle gap).
module adc_pkt_stream #(
  parameter int NUM_CH = 8,
  parameter int DATA_W = 18,
  parameter int LEN_W  = 16,
  parameter int IDLE_W = 16
) (
  input  logic                     clk_200m,
  input  logic                     rst_200m,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  input  logic [NUM_CH-1:0]        ch_valid,
  output logic [NUM_CH-1:0]        ch_ready,
  input  logic [NUM_CH-1:0]        rf_ch_mask,
  input  logic                     rf_capture_start,
  input  logic                     rf_capture_again,
  input  logic                     rf_capture_stop,
  input  logic [LEN_W-1:0]         rf_pkt_data_length,
  input  logic [IDLE_W-1:0]        rf_pkt_idle_length,
  input  logic [7:0]               rf_pkt_num,
  output logic [DATA_W-1:0]        ADC_DATA,
  output logic                     ADC_DATA_VALID,
  output logic                     ADC_DATA_SOP,
  output logic                     busy,
  output logic [7:0]               pkt_seq,
  output logic                     err_underrun
);

  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_TRL, S_GAP, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [LEN_W-1:0]   wcnt_q, wcnt_d, len_q, len_d, len_eff;
  logic [IDLE_W-1:0]  icnt_q, icnt_d, idle_q, idle_d;
  logic [NUM_CH-1:0]  mask_q, mask_d;
  logic [7:0]         num_q, num_d, seq_q, seq_d, sent_q, sent_d;
  logic               stop_q, stop_d, err_q, err_d;
  logic [DATA_W-1:0]  data_q, data_d, sample;
  logic               vld_q, vld_d, sop_q, sop_d;
  logic               payload_done, pkt_end;

  function automatic logic [PTR_W-1:0] lowest_ch(input logic [NUM_CH-1:0] m);
    lowest_ch = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (m[i]) lowest_ch = PTR_W'(i);
  endfunction

  // Scan downwards so the smallest forward distance from p wins.
  function automatic logic [PTR_W-1:0] next_ch(input logic [NUM_CH-1:0] m,
                                               input logic [PTR_W-1:0]  p);
    int idx;
    next_ch = p;
    for (int i = NUM_CH - 1; i >= 1; i--) begin
      idx = (int'(p) + i) % NUM_CH;
      if (m[idx]) next_ch = PTR_W'(idx);
    end
  endfunction

`ifdef PKT_CRC_EN
  logic [15:0] crc_q, crc_d;
  logic [31:0] crc_ext;

  // CRC-16/CCITT over bits [15:0] of one word, MSB first.
  function automatic logic [15:0] crc16_word(input logic [15:0] c, input logic [DATA_W-1:0] d);
    logic [31:0] e;
    e = 32'(d);
    for (int b = 15; b >= 0; b--)
      c = (c[15] ^ e[b]) ? ((c << 1) ^ 16'h1021) : (c << 1);
    return c;
  endfunction

  assign crc_ext = {16'h0, crc_q};
`endif

  assign sample       = ch_data[int'(ptr_q)*DATA_W +: DATA_W];
  assign busy         = (state_q != S_IDLE) && (state_q != S_DONE);
  assign len_eff      = (len_q == '0) ? LEN_W'(1) : len_q;
  assign ADC_DATA     = data_q;
  assign ADC_DATA_VALID = vld_q;
  assign ADC_DATA_SOP = sop_q;
  assign pkt_seq      = seq_q;
  assign err_underrun = err_q;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_d = state_q;  ptr_d  = ptr_q;  wcnt_d = wcnt_q; icnt_d = icnt_q;
    mask_d  = mask_q;   len_d  = len_q;  idle_d = idle_q; num_d  = num_q;
    seq_d   = seq_q;    sent_d = sent_q; stop_d = stop_q; err_d  = err_q;
    data_d  = '0;       vld_d  = 1'b0;   sop_d  = 1'b0;   ch_ready = '0;
    payload_done = 1'b0;
    pkt_end      = 1'b0;
`ifdef PKT_CRC_EN
    crc_d = crc_q;
`endif
    if (busy && rf_capture_stop) stop_d = 1'b1;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (rf_ch_mask != '0 &&
            (rf_capture_start || (state_q == S_DONE && rf_capture_again))) begin
          mask_d  = rf_ch_mask;
          len_d   = rf_pkt_data_length;
          idle_d  = rf_pkt_idle_length;
          num_d   = rf_pkt_num;
          ptr_d   = lowest_ch(rf_ch_mask);
          sent_d  = '0;
          state_d = S_HDR;
          if (rf_capture_start) begin
            seq_d = '0;
            err_d = 1'b0;
          end
        end
      end
      S_HDR: begin
        data_d[DATA_W-1 -: 4] = 4'hA;
        data_d[7:0]           = seq_q;
        vld_d   = 1'b1;
        sop_d   = 1'b1;
        wcnt_d  = '0;
        state_d = S_DATA;
`ifdef PKT_CRC_EN
        crc_d = 16'hFFFF;
`endif
      end
      S_DATA: begin
        if (ch_valid[ptr_q]) begin
          ch_ready[ptr_q] = 1'b1;
          data_d = sample;
          vld_d  = 1'b1;
          ptr_d  = next_ch(mask_q, ptr_q);
`ifdef PKT_CRC_EN
          crc_d = crc16_word(crc_q, sample);
`endif
          if (wcnt_q == len_eff - 1'b1) begin
`ifdef PKT_CRC_EN
            state_d = S_TRL;
`else
            payload_done = 1'b1;
`endif
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end else begin
          err_d = 1'b1;
        end
      end
      S_TRL: begin
`ifdef PKT_CRC_EN
        data_d = crc_ext[DATA_W-1:0];
        vld_d  = 1'b1;
`endif
        payload_done = 1'b1;
      end
      S_GAP: begin
        if (icnt_q == idle_q - 1'b1) pkt_end = 1'b1;
        else                         icnt_d  = icnt_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (payload_done) begin
      if (idle_q == '0) begin
        pkt_end = 1'b1;
      end else begin
        state_d = S_GAP;
        icnt_d  = '0;
      end
    end

    // stop_d already folds in a stop pulse arriving this very cycle.
    if (pkt_end) begin
      seq_d  = seq_q + 8'd1;
      sent_d = sent_q + 8'd1;
      if (stop_d || (num_q != '0 && sent_q + 8'd1 == num_q)) begin
        state_d = S_DONE;
        stop_d  = 1'b0;
      end else begin
        state_d = S_HDR;
      end
    end

    // Never pop a source while the block is being reset.
    if (rst_200m) ch_ready = '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_200m) begin
    if (rst_200m) begin
      state_q <= S_IDLE; ptr_q  <= '0; wcnt_q <= '0; icnt_q <= '0;
      mask_q  <= '0;     len_q  <= '0; idle_q <= '0; num_q  <= '0;
      seq_q   <= '0;     sent_q <= '0; stop_q <= 1'b0; err_q <= 1'b0;
      data_q  <= '0;     vld_q  <= 1'b0; sop_q <= 1'b0;
`ifdef PKT_CRC_EN
      crc_q   <= '0;
`endif
    end else begin
      state_q <= state_d; ptr_q  <= ptr_d;  wcnt_q <= wcnt_d; icnt_q <= icnt_d;
      mask_q  <= mask_d;  len_q  <= len_d;  idle_q <= idle_d; num_q  <= num_d;
      seq_q   <= seq_d;   sent_q <= sent_d; stop_q <= stop_d; err_q  <= err_d;
      data_q  <= data_d;  vld_q  <= vld_d;  sop_q  <= sop_d;
`ifdef PKT_CRC_EN
      crc_q   <= crc_d;
`endif
    end
  end

endmodule

// File: tb/tb_adc_pkt_stream.sv
// Bench for adc_pkt_stream: table of capture configs, directed corner sequences and
// randomized ch_valid traffic, all compared against a packet-level stream model.
module tb_adc_pkt_stream;
  localparam int NCH = 8, DW = 18, LW = 16, IW = 16;
`ifdef PKT_CRC_EN
  localparam int CRC_X = 1;
`else
  localparam int CRC_X = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, start, again, stop;
  logic [NCH*DW-1:0] ch_data;
  logic [NCH-1:0]    ch_valid, ch_ready, cfg_mask;
  logic [LW-1:0]     cfg_len;
  logic [IW-1:0]     cfg_idle;
  logic [7:0]        cfg_num, pkt_seq;
  logic [DW-1:0]     adc_data;
  logic              adc_vld, adc_sop, busy, err;

  adc_pkt_stream #(.NUM_CH(NCH), .DATA_W(DW), .LEN_W(LW), .IDLE_W(IW)) dut (
    .clk_200m(clk), .rst_200m(rst), .ch_data(ch_data), .ch_valid(ch_valid),
    .ch_ready(ch_ready), .rf_ch_mask(cfg_mask), .rf_capture_start(start),
    .rf_capture_again(again), .rf_capture_stop(stop),
    .rf_pkt_data_length(cfg_len), .rf_pkt_idle_length(cfg_idle), .rf_pkt_num(cfg_num),
    .ADC_DATA(adc_data), .ADC_DATA_VALID(adc_vld), .ADC_DATA_SOP(adc_sop),
    .busy(busy), .pkt_seq(pkt_seq), .err_underrun(err)
  );

  typedef logic [DW:0] beat_t;  // {sop, data}
  typedef struct { logic vld; logic sop; logic busy; logic [DW-1:0] data; } log_t;
  typedef struct {
    logic [7:0] mask; int len; int idle; int num;
    int beats; int busy_cyc; int holes; logic [7:0] end_seq;
  } vec_t;

  beat_t exp_q[$], obs_q[$];
  log_t  log_q[$];
  vec_t  tbl[5];
  int    pops[NCH], m_pops[NCH];
  logic [7:0] m_seq;
  int    n_checks = 0, n_errors = 0;
  bit    rand_valid = 1'b0;

  function automatic logic [DW-1:0] samp(input int ch, input int k);
    return DW'(ch * 4096 + 49 + k);
  endfunction

  function automatic logic [DW-1:0] hdr_word(input logic [7:0] s);
    logic [DW-1:0] h;
    h = '0;
    h[DW-1 -: 4] = 4'hA;
    h[7:0] = s;
    return h;
  endfunction

  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [15:0] d);
    for (int b = 15; b >= 0; b--)
      c = (c[15] ^ d[b]) ? ((c << 1) ^ 16'h1021) : (c << 1);
    return c;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_sources();
    for (int i = 0; i < NCH; i++) ch_data[i*DW +: DW] = samp(i, pops[i]);
  endtask

  task automatic reset_sources();
    for (int i = 0; i < NCH; i++) begin
      pops[i] = 0;
      m_pops[i] = 0;
    end
    drive_sources();
  endtask

  // One clock: observe at the falling edge, then update sources just after the rising edge.
  task automatic cycle();
    logic [NCH-1:0] rdy;
    @(negedge clk);
    log_q.push_back('{adc_vld, adc_sop, busy, adc_data});
    if (adc_vld) obs_q.push_back({adc_sop, adc_data});
    rdy = ch_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NCH; i++) if (rdy[i]) pops[i]++;
    drive_sources();
    if (rand_valid) ch_valid = NCH'($urandom() | $urandom());
  endtask

  task automatic clear_logs();
    exp_q.delete();
    obs_q.delete();
    log_q.delete();
  endtask

  task automatic set_cfg(input logic [7:0] m, input int l, input int i, input int n);
    cfg_mask = m;
    cfg_len  = LW'(l);
    cfg_idle = IW'(i);
    cfg_num  = 8'(n);
  endtask

  // Expected pad stream for npkt packets: channels visited in ascending order of the
  // enabled set, cycling, restarting at the lowest enabled channel on each start/again.
  task automatic model_capture(input logic [7:0] m, input int l, input int npkt, input bit fresh);
    int en[$];
    int idx, ch, nw;
    logic [DW-1:0] v;
    logic [15:0] crc;
    for (int i = 0; i < NCH; i++) if (m[i]) en.push_back(i);
    if (fresh) m_seq = 8'd0;
    idx = 0;
    nw = (l == 0) ? 1 : l;
    for (int p = 0; p < npkt; p++) begin
      exp_q.push_back({1'b1, hdr_word(m_seq)});
      crc = 16'hFFFF;
      for (int w = 0; w < nw; w++) begin
        ch = en[idx];
        v = samp(ch, m_pops[ch]);
        m_pops[ch]++;
        exp_q.push_back({1'b0, v});
        crc = crc_upd(crc, v[15:0]);
        idx = (idx + 1) % en.size();
      end
`ifdef PKT_CRC_EN
      exp_q.push_back({1'b0, DW'(crc)});
`endif
      m_seq = m_seq + 8'd1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic run_to_done();
    bit done = 1'b0;
    for (int n = 0; n < 2000 && !done; n++) begin
      cycle();
      done = !log_q[$].busy;
    end
    check("capture_timeout", done, 1'b1);
    repeat (3) cycle();
  endtask

  task automatic compare_stream(input string tag);
    int n;
    check({tag, "_beats"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check($sformatf("%s_beat%0d", tag, i), obs_q[i], exp_q[i]);
  endtask

  function automatic int busy_cycles();
    int c = 0;
    foreach (log_q[i]) if (log_q[i].busy) c++;
    return c;
  endfunction

  // Invalid cycles between the first and last valid word.
  function automatic int holes();
    int first = -1, last = -1, h = 0;
    foreach (log_q[i]) if (log_q[i].vld) begin
      if (first < 0) first = i;
      last = i;
    end
    if (first < 0) return 0;
    for (int i = first; i <= last; i++) if (!log_q[i].vld) h++;
    return h;
  endfunction

  initial begin
    logic [7:0] rm;
    int rl, ri, rn;
    tbl[0] = '{8'h05, 4, 3, 2, 10, 16, 3, 8'd2};
    tbl[1] = '{8'h01, 0, 0, 3,  6,  6, 0, 8'd3};
    tbl[2] = '{8'hFF, 3, 1, 1,  4,  5, 0, 8'd1};
    tbl[3] = '{8'h81, 2, 0, 2,  6,  6, 0, 8'd2};
    tbl[4] = '{8'h0A, 5, 2, 2, 12, 16, 2, 8'd2};

    rst = 1'b1; start = 1'b0; again = 1'b0; stop = 1'b0;
    ch_valid = '1;
    set_cfg(8'h00, 0, 0, 0);
    reset_sources();
    repeat (3) cycle();
    check("rst_data", adc_data, 0);
    check("rst_valid", adc_vld, 0);
    check("rst_sop", adc_sop, 0);
    check("rst_busy", busy, 0);
    check("rst_seq", pkt_seq, 0);
    check("rst_err", err, 0);
    check("rst_ready", ch_ready, 0);
    rst = 1'b0;
    cycle();

    // again from IDLE is ignored
    clear_logs();
    set_cfg(8'h01, 2, 0, 1);
    again = 1'b1;
    cycle();
    again = 1'b0;
    repeat (4) cycle();
    check("again_idle_busy", busy_cycles(), 0);
    check("again_idle_beats", obs_q.size(), 0);

    foreach (tbl[t]) begin
      clear_logs();
      reset_sources();
      set_cfg(tbl[t].mask, tbl[t].len, tbl[t].idle, tbl[t].num);
      model_capture(tbl[t].mask, tbl[t].len, tbl[t].num, 1'b1);
      pulse_start();
      run_to_done();
      compare_stream($sformatf("tbl%0d", t));
      check($sformatf("tbl%0d_nbeats", t), obs_q.size(), tbl[t].beats + tbl[t].num * CRC_X);
      check($sformatf("tbl%0d_busy", t), busy_cycles(), tbl[t].busy_cyc + tbl[t].num * CRC_X);
      check($sformatf("tbl%0d_holes", t), holes(), tbl[t].holes);
      check($sformatf("tbl%0d_seq", t), pkt_seq, tbl[t].end_seq);
    end

    // start with an empty mask is ignored (from DONE)
    clear_logs();
    set_cfg(8'h00, 4, 1, 1);
    pulse_start();
    repeat (5) cycle();
    check("mask0_busy", busy_cycles(), 0);
    check("mask0_beats", obs_q.size(), 0);

    // underrun: ch_valid[0] low for two DATA cycles
    clear_logs();
    reset_sources();
    set_cfg(8'h01, 3, 2, 1);
    model_capture(8'h01, 3, 1, 1'b1);
    pulse_start();
    cycle();
    cycle();
    ch_valid[0] = 1'b0;
    cycle();
    cycle();
    ch_valid = '1;
    run_to_done();
    compare_stream("underrun");
    check("underrun_holes", holes(), 2);
    check("underrun_err", err, 1);

    // stop (with a simultaneous start, which must lose) during the 3rd payload word
    clear_logs();
    reset_sources();
    set_cfg(8'h01, 8, 2, 0);
    model_capture(8'h01, 8, 1, 1'b1);
    check("err_sticky", err, 1);
    pulse_start();
    check("err_cleared", err, 0);
    cycle();
    cycle();
    cycle();
    stop = 1'b1;
    start = 1'b1;
    cycle();
    stop = 1'b0;
    start = 1'b0;
    run_to_done();
    compare_stream("stop");
    check("stop_busy", busy_cycles(), 11 + CRC_X);
    check("stop_seq", pkt_seq, 1);

    clear_logs();
    set_cfg(8'h01, 8, 2, 1);
    model_capture(8'h01, 8, 1, 1'b0);
    again = 1'b1;
    cycle();
    again = 1'b0;
    run_to_done();
    check("again_hdr", (obs_q.size() > 0) ? obs_q[0] : beat_t'('0), {1'b1, hdr_word(8'd1)});
    compare_stream("again");
    check("again_seq", pkt_seq, 2);

    // randomized source availability
    rand_valid = 1'b1;
    for (int r = 0; r < 6; r++) begin
      rm = 8'($urandom_range(1, 255));
      rl = $urandom_range(0, 6);
      ri = $urandom_range(0, 3);
      rn = $urandom_range(1, 3);
      clear_logs();
      reset_sources();
      set_cfg(rm, rl, ri, rn);
      model_capture(rm, rl, rn, 1'b1);
      pulse_start();
      run_to_done();
      compare_stream($sformatf("rnd%0d", r));
      check($sformatf("rnd%0d_seq", r), pkt_seq, rn);
    end
    rand_valid = 1'b0;
    ch_valid = '1;

`ifdef PKT_CRC_EN
    // payload 0x0031, 0x0032 then 0x0033, 0x0034: trailer per packet, CRC re-seeded
    clear_logs();
    reset_sources();
    set_cfg(8'h01, 2, 1, 2);
    model_capture(8'h01, 2, 2, 1'b1);
    pulse_start();
    run_to_done();
    compare_stream("crc");
    check("crc_trl0", (obs_q.size() > 3) ? obs_q[3] : beat_t'('0),
          {1'b0, DW'(crc_upd(crc_upd(16'hFFFF, 16'h0031), 16'h0032))});
`endif

    // reset in the middle of the payload
    clear_logs();
    reset_sources();
    set_cfg(8'h01, 8, 0, 0);
    pulse_start();
    cycle();
    cycle();
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("midrst_data", adc_data, 0);
    check("midrst_valid", adc_vld, 0);
    check("midrst_sop", adc_sop, 0);
    check("midrst_busy", busy, 0);
    check("midrst_ready", ch_ready, 0);
    check("midrst_seq", pkt_seq, 0);
    clear_logs();
    repeat (5) cycle();
    check("midrst_no_trailer", obs_q.size(), 0);
    check("midrst_idle", busy_cycles(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
